// File: rtl/fpu_interco_pkg.sv
// Shared types and defaults for the core<->FPU interconnect slice.
// Default widths match the cluster FPU configuration.
package fpu_interco_pkg;
  localparam int NB_CORES_DEF        = 4;
  localparam int DATA_WIDTH_DEF      = 32;
  localparam int NB_ARGS_DEF         = 3;
  localparam int OPCODE_WIDTH_DEF    = 6;
  localparam int DSFLAGS_CPU_DEF     = 15;
  localparam int USFLAGS_CPU_DEF     = 5;
  localparam int MAX_OUTSTANDING_DEF = 4;

  localparam int CORE_ID_W = $clog2(NB_CORES_DEF);
  typedef logic [CORE_ID_W-1:0] core_id_t;

  // Responses with no owner are always accepted so the FPU never stalls on them.
  localparam logic ORPHAN_DRAIN_RREADY = 1'b1;
endpackage

// File: rtl/fpu_id_fifo.sv
// In-order FIFO of granted core IDs; the head names the owner of the next FPU response.
// Synchronous active-high reset; push is accepted when full only together with a pop.
module fpu_id_fifo
  import fpu_interco_pkg::*;
#(
  parameter int DEPTH = MAX_OUTSTANDING_DEF,
  parameter int ID_W  = CORE_ID_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [ID_W-1:0] push_id,
  output logic [ID_W-1:0] head_id,
  output logic            full,
  output logic            empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ID_W-1:0]  mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == '0);
  assign pop_ok_s  = pop & ~empty;
  assign push_ok_s = push & (~full | pop_ok_s);
  assign head_id   = mem_r[rd_ptr_r];

  // ID storage, written at the tail on every accepted push.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_id;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (pop_ok_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: rtl/fpu_share_arbiter.sv
// Merges NB_CORES core request ports onto one shared FPU: round-robin grant,
// in-order response routing via an ID FIFO. Optional FPU_SHARE_ARB_PERF_EN adds stall counters.
module fpu_share_arbiter
  import fpu_interco_pkg::*;
#(
  parameter int NB_CORES        = NB_CORES_DEF,
  parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int NB_ARGS         = NB_ARGS_DEF,
  parameter int OPCODE_WIDTH    = OPCODE_WIDTH_DEF,
  parameter int DSFLAGS_CPU     = DSFLAGS_CPU_DEF,
  parameter int USFLAGS_CPU     = USFLAGS_CPU_DEF,
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NB_CORES-1:0]                    core_req_i,
  output logic [NB_CORES-1:0]                    core_gnt_o,
  input  logic [NB_CORES*NB_ARGS*DATA_WIDTH-1:0] core_operands_i,
  input  logic [NB_CORES*OPCODE_WIDTH-1:0]       core_op_i,
  input  logic [NB_CORES*DSFLAGS_CPU-1:0]        core_flags_i,
  input  logic [NB_CORES-1:0]                    core_rready_i,
  output logic [NB_CORES-1:0]                    core_rvalid_o,
  output logic [DATA_WIDTH-1:0]                  core_rdata_o,
  output logic [USFLAGS_CPU-1:0]                 core_rflags_o,
  output logic                                   fpu_req_o,
  input  logic                                   fpu_gnt_i,
  output logic [NB_ARGS*DATA_WIDTH-1:0]          fpu_operands_o,
  output logic [OPCODE_WIDTH-1:0]                fpu_op_o,
  output logic [DSFLAGS_CPU-1:0]                 fpu_flags_o,
  output logic                                   fpu_rready_o,
  input  logic                                   fpu_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                  fpu_rdata_i,
  input  logic [USFLAGS_CPU-1:0]                 fpu_rflags_i,
  output logic                                   err_orphan_o
`ifdef FPU_SHARE_ARB_PERF_EN
  ,
  output logic [NB_CORES*32-1:0]                 perf_stall_o
`endif
);
  localparam int ID_W  = $clog2(NB_CORES);
  localparam int OPS_W = NB_ARGS * DATA_WIDTH;

  logic [ID_W-1:0] rr_ptr_r;
  logic [ID_W-1:0] winner_s;
  logic [ID_W-1:0] cand_s;
  logic [ID_W-1:0] head_s;
  logic            any_req_s;
  logic            req_s;
  logic            push_s;
  logic            pop_s;
  logic            rready_s;
  logic            full_s;
  logic            empty_s;
  logic            err_orphan_r;

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (id == ID_W'(NB_CORES - 1)) ? '0 : id + ID_W'(1);
  endfunction

  // Round-robin pick: first requester at or after rr_ptr, wrapping at NB_CORES.
  always_comb begin
    winner_s  = rr_ptr_r;
    any_req_s = 1'b0;
    cand_s    = rr_ptr_r;
    for (int k = 0; k < NB_CORES; k++) begin
      if (!any_req_s && core_req_i[cand_s]) begin
        any_req_s = 1'b1;
        winner_s  = cand_s;
      end else begin
        any_req_s = any_req_s;
      end
      cand_s = next_id(cand_s);
    end
  end

  // A full ID FIFO holds off new grants so every accepted op has a slot.
  assign req_s  = ~rst & any_req_s & ~full_s;
  assign push_s = req_s & fpu_gnt_i;

  // Grant fan-out to the winning core only.
  always_comb begin
    core_gnt_o = '0;
    if (req_s) begin
      core_gnt_o[winner_s] = fpu_gnt_i;
    end else begin
      core_gnt_o = '0;
    end
  end

  assign fpu_req_o      = req_s;
  assign fpu_operands_o = core_operands_i[int'(winner_s)*OPS_W +: OPS_W];
  assign fpu_op_o       = core_op_i[int'(winner_s)*OPCODE_WIDTH +: OPCODE_WIDTH];
  assign fpu_flags_o    = core_flags_i[int'(winner_s)*DSFLAGS_CPU +: DSFLAGS_CPU];

  // Response routing by FIFO head; with no owner the response is drained.
  always_comb begin
    core_rvalid_o = '0;
    if (!rst && !empty_s) begin
      core_rvalid_o[head_s] = fpu_rvalid_i;
      rready_s              = core_rready_i[head_s];
    end else begin
      rready_s = ORPHAN_DRAIN_RREADY;
    end
  end

  assign pop_s         = fpu_rvalid_i & rready_s & ~empty_s;
  assign fpu_rready_o  = rready_s;
  assign core_rdata_o  = fpu_rdata_i;
  assign core_rflags_o = fpu_rflags_i;
  assign err_orphan_o  = err_orphan_r;

  fpu_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .ID_W  (ID_W)
  ) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_s),
    .pop     (pop_s),
    .push_id (winner_s),
    .head_id (head_s),
    .full    (full_s),
    .empty   (empty_s)
  );

  // Round-robin pointer moves past the winner only on an accepted grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r <= '0;
    end else if (push_s) begin
      rr_ptr_r <= next_id(winner_s);
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Sticky orphan-response flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_orphan_r <= 1'b0;
    end else if (fpu_rvalid_i && empty_s) begin
      err_orphan_r <= 1'b1;
    end else begin
      err_orphan_r <= err_orphan_r;
    end
  end

`ifdef FPU_SHARE_ARB_PERF_EN
  for (genvar i = 0; i < NB_CORES; i++) begin : g_perf
    logic [31:0] stall_cnt_r;

    // Saturating count of cycles this core requested without a grant.
    always_ff @(posedge clk) begin
      if (rst) begin
        stall_cnt_r <= 32'd0;
      end else if (core_req_i[i] && !core_gnt_o[i] && (stall_cnt_r != 32'hFFFF_FFFF)) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end

    assign perf_stall_o[i*32 +: 32] = stall_cnt_r;
  end
`endif
endmodule

// File: tb/tb_fpu_share_arbiter.sv
// Scoreboard bench for fpu_share_arbiter: granted IDs are queued at grant time and
// checked against the one-hot response routing. Define FPU_SHARE_ARB_PERF_EN to cover stall counters.
module tb_fpu_share_arbiter;
  localparam int NB = 4, DW = 32, NA = 3, OW = 6, DS = 15, US = 5, MO = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NB-1:0]     core_req_i = '0;
  logic [NB-1:0]     core_gnt_o;
  logic [NB*NA*DW-1:0] core_operands_i;
  logic [NB*OW-1:0]  core_op_i;
  logic [NB*DS-1:0]  core_flags_i;
  logic [NB-1:0]     core_rready_i = '0;
  logic [NB-1:0]     core_rvalid_o;
  logic [DW-1:0]     core_rdata_o;
  logic [US-1:0]     core_rflags_o;
  logic              fpu_req_o;
  logic              fpu_gnt_i = 1'b0;
  logic [NA*DW-1:0]  fpu_operands_o;
  logic [OW-1:0]     fpu_op_o;
  logic [DS-1:0]     fpu_flags_o;
  logic              fpu_rready_o;
  logic              fpu_rvalid_i = 1'b0;
  logic [DW-1:0]     fpu_rdata_i = '0;
  logic [US-1:0]     fpu_rflags_i = '0;
  logic              err_orphan_o;
`ifdef FPU_SHARE_ARB_PERF_EN
  logic [NB*32-1:0]  perf_stall_o;
`endif

  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  fpu_share_arbiter #(
    .NB_CORES(NB), .DATA_WIDTH(DW), .NB_ARGS(NA), .OPCODE_WIDTH(OW),
    .DSFLAGS_CPU(DS), .USFLAGS_CPU(US), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .rst(rst),
    .core_req_i(core_req_i), .core_gnt_o(core_gnt_o),
    .core_operands_i(core_operands_i), .core_op_i(core_op_i), .core_flags_i(core_flags_i),
    .core_rready_i(core_rready_i), .core_rvalid_o(core_rvalid_o),
    .core_rdata_o(core_rdata_o), .core_rflags_o(core_rflags_o),
    .fpu_req_o(fpu_req_o), .fpu_gnt_i(fpu_gnt_i),
    .fpu_operands_o(fpu_operands_o), .fpu_op_o(fpu_op_o), .fpu_flags_o(fpu_flags_o),
    .fpu_rready_o(fpu_rready_o), .fpu_rvalid_i(fpu_rvalid_i),
    .fpu_rdata_i(fpu_rdata_i), .fpu_rflags_i(fpu_rflags_i),
    .err_orphan_o(err_orphan_o)
`ifdef FPU_SHARE_ARB_PERF_EN
    , .perf_stall_o(perf_stall_o)
`endif
  );

  function automatic logic [NA*DW-1:0] ops_of(input int c);
    logic [DW-1:0] w;
    w = 32'hC0DE_0000 + 32'(c);
    return {w, w, w};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    core_req_i = 4'b1111; fpu_gnt_i = 1'b1; fpu_rvalid_i = 1'b1;
    #1;
    vectors++; if (fpu_req_o !== 1'b0) begin miscompares++; $display("FAIL rst_req got=%0b exp=0", fpu_req_o); end
    vectors++; if (core_gnt_o !== 4'b0000) begin miscompares++; $display("FAIL rst_gnt got=%b exp=0000", core_gnt_o); end
    vectors++; if (core_rvalid_o !== 4'b0000) begin miscompares++; $display("FAIL rst_rvalid got=%b exp=0000", core_rvalid_o); end
    @(negedge clk);
    rst = 1'b0; core_req_i = '0; fpu_gnt_i = 1'b0; fpu_rvalid_i = 1'b0;
    #1;
    vectors++; if (err_orphan_o !== 1'b0) begin miscompares++; $display("FAIL rst_err got=%0b exp=0", err_orphan_o); end
    vectors++; if (fpu_req_o !== 1'b0) begin miscompares++; $display("FAIL idle_req got=%0b exp=0", fpu_req_o); end
  endtask

  // Cores 0,2 alternate until the FIFO fills; one pop frees a slot for the next grant.
  task automatic test_rr_and_full();
    logic [NB-1:0] exp_gnt [4] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
    int exp_id [4] = '{0, 2, 0, 2};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      core_req_i = 4'b0101; fpu_gnt_i = 1'b1; core_rready_i = 4'b1111;
      #1;
      vectors++; if (core_gnt_o !== exp_gnt[c]) begin miscompares++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", c, core_gnt_o, exp_gnt[c]); end
      vectors++; if (fpu_op_o !== 6'(exp_id[c] + 8)) begin miscompares++; $display("FAIL rr_op[%0d] got=%0d exp=%0d", c, fpu_op_o, exp_id[c] + 8); end
      vectors++; if (fpu_operands_o !== ops_of(exp_id[c])) begin miscompares++; $display("FAIL rr_ops[%0d] got=%h", c, fpu_operands_o); end
      vectors++; if (fpu_flags_o !== 15'(exp_id[c] * 3 + 1)) begin miscompares++; $display("FAIL rr_flags[%0d] got=%0d exp=%0d", c, fpu_flags_o, exp_id[c] * 3 + 1); end
      exp_q.push_back(exp_id[c]);
    end
    @(negedge clk); #1;
    vectors++; if (fpu_req_o !== 1'b0) begin miscompares++; $display("FAIL full_req got=%0b exp=0", fpu_req_o); end
    vectors++; if (core_gnt_o !== 4'b0000) begin miscompares++; $display("FAIL full_gnt got=%b exp=0000", core_gnt_o); end
    @(negedge clk);
    fpu_rvalid_i = 1'b1; fpu_rdata_i = 32'h1111_0000;
    #1;
    vectors++; if (core_rvalid_o !== 4'(1 << exp_q[0])) begin miscompares++; $display("FAIL full_pop_rvalid got=%b exp_id=%0d", core_rvalid_o, exp_q[0]); end
    vectors++; if (fpu_req_o !== 1'b0) begin miscompares++; $display("FAIL full_pop_req got=%0b exp=0", fpu_req_o); end
    void'(exp_q.pop_front());
    @(negedge clk);
    fpu_rvalid_i = 1'b0;
    #1;
    vectors++; if (core_gnt_o !== 4'b0001) begin miscompares++; $display("FAIL resume_gnt got=%b exp=0001", core_gnt_o); end
    exp_q.push_back(0);
    @(negedge clk); #1;
    vectors++; if (fpu_req_o !== 1'b0) begin miscompares++; $display("FAIL refull_req got=%0b exp=0", fpu_req_o); end
    core_req_i = '0; fpu_gnt_i = 1'b0;
  endtask

  task automatic test_drain();
    int id;
    for (int c = 0; c < MO; c++) begin
      @(negedge clk);
      fpu_rvalid_i = 1'b1; fpu_rdata_i = 32'hABC0_0000 + 32'(c); fpu_rflags_i = 5'(c + 3); core_rready_i = 4'b1111;
      #1;
      id = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
      vectors++; if (core_rvalid_o !== 4'(1 << id)) begin miscompares++; $display("FAIL drain_rvalid[%0d] got=%b exp_id=%0d", c, core_rvalid_o, id); end
      vectors++; if (core_rdata_o !== 32'hABC0_0000 + 32'(c)) begin miscompares++; $display("FAIL drain_rdata[%0d] got=%h", c, core_rdata_o); end
      vectors++; if (core_rflags_o !== 5'(c + 3)) begin miscompares++; $display("FAIL drain_rflags[%0d] got=%0d exp=%0d", c, core_rflags_o, c + 3); end
    end
    @(negedge clk);
    fpu_rvalid_i = 1'b0;
    #1;
    vectors++; if (err_orphan_o !== 1'b0) begin miscompares++; $display("FAIL drain_err got=%0b exp=0", err_orphan_o); end
  endtask

  // FIFO {1,3}; core 1 back-pressures the response, then accepts it.
  task automatic test_response_hold();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      core_req_i = 4'b1010; fpu_gnt_i = 1'b1;
      #1;
      vectors++; if (core_gnt_o !== ((c == 0) ? 4'b0010 : 4'b1000)) begin miscompares++; $display("FAIL hold_gnt[%0d] got=%b", c, core_gnt_o); end
      exp_q.push_back((c == 0) ? 1 : 3);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      core_req_i = '0; fpu_gnt_i = 1'b0;
      fpu_rvalid_i = 1'b1; fpu_rdata_i = 32'h3F80_0000; core_rready_i = 4'b1101;
      #1;
      vectors++; if (core_rvalid_o !== 4'b0010) begin miscompares++; $display("FAIL hold_rvalid[%0d] got=%b exp=0010", c, core_rvalid_o); end
      vectors++; if (fpu_rready_o !== 1'b0) begin miscompares++; $display("FAIL hold_rready[%0d] got=%0b exp=0", c, fpu_rready_o); end
      vectors++; if (core_rdata_o !== 32'h3F80_0000) begin miscompares++; $display("FAIL hold_rdata got=%h exp=3f800000", core_rdata_o); end
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      core_rready_i = 4'b1111;
      #1;
      vectors++; if (core_rvalid_o !== 4'(1 << exp_q[0])) begin miscompares++; $display("FAIL accept_rvalid[%0d] got=%b exp_id=%0d", c, core_rvalid_o, exp_q[0]); end
      vectors++; if (fpu_rready_o !== 1'b1) begin miscompares++; $display("FAIL accept_rready[%0d] got=%0b exp=1", c, fpu_rready_o); end
      void'(exp_q.pop_front());
    end
    @(negedge clk);
    fpu_rvalid_i = 1'b0;
  endtask

  task automatic test_orphan();
    @(negedge clk);
    fpu_rvalid_i = 1'b1; core_rready_i = 4'b0000;
    #1;
    vectors++; if (fpu_rready_o !== 1'b1) begin miscompares++; $display("FAIL orphan_rready got=%0b exp=1", fpu_rready_o); end
    vectors++; if (core_rvalid_o !== 4'b0000) begin miscompares++; $display("FAIL orphan_rvalid got=%b exp=0000", core_rvalid_o); end
    vectors++; if (err_orphan_o !== 1'b0) begin miscompares++; $display("FAIL orphan_err_early got=%0b exp=0", err_orphan_o); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      fpu_rvalid_i = 1'b0;
      #1;
      vectors++; if (err_orphan_o !== 1'b1) begin miscompares++; $display("FAIL orphan_err_sticky[%0d] got=%0b exp=1", c, err_orphan_o); end
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    vectors++; if (err_orphan_o !== 1'b0) begin miscompares++; $display("FAIL orphan_err_clr got=%0b exp=0", err_orphan_o); end
    // Reset with an op in flight: the late response becomes an orphan.
    @(negedge clk);
    core_req_i = 4'b0001; fpu_gnt_i = 1'b1;
    @(negedge clk);
    core_req_i = '0; fpu_gnt_i = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; fpu_rvalid_i = 1'b1; core_rready_i = 4'b1111;
    #1;
    vectors++; if (core_rvalid_o !== 4'b0000) begin miscompares++; $display("FAIL late_rvalid got=%b exp=0000", core_rvalid_o); end
    @(negedge clk);
    fpu_rvalid_i = 1'b0;
    #1;
    vectors++; if (err_orphan_o !== 1'b1) begin miscompares++; $display("FAIL late_err got=%0b exp=1", err_orphan_o); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

`ifdef FPU_SHARE_ARB_PERF_EN
  task automatic test_perf();
    @(negedge clk);
    core_req_i = 4'b0011; fpu_gnt_i = 1'b0;
    repeat (5) @(negedge clk);
    core_req_i = '0;
    #1;
    vectors++; if (perf_stall_o[32 +: 32] !== 32'd5) begin miscompares++; $display("FAIL perf_stall1 got=%0d exp=5", perf_stall_o[32 +: 32]); end
    vectors++; if (perf_stall_o[64 +: 32] !== 32'd0) begin miscompares++; $display("FAIL perf_stall2 got=%0d exp=0", perf_stall_o[64 +: 32]); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    vectors++; if (perf_stall_o[32 +: 32] !== 32'd0) begin miscompares++; $display("FAIL perf_clr got=%0d exp=0", perf_stall_o[32 +: 32]); end
  endtask
`endif

  initial begin
    for (int i = 0; i < NB; i++) begin
      core_operands_i[i*NA*DW +: NA*DW] = ops_of(i);
      core_op_i[i*OW +: OW]             = 6'(i + 8);
      core_flags_i[i*DS +: DS]          = 15'(i * 3 + 1);
    end
    test_reset();
    test_rr_and_full();
    test_drain();
    test_response_hold();
    test_orphan();
`ifdef FPU_SHARE_ARB_PERF_EN
    test_perf();
`endif
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
